// File: rtl/tc_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc_axi_pkg
// Description : Shared types and helpers for the host-side AXI read packer.
// Revision    : 1.0 - initial release
// ============================================================================
package tc_axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_R_DATA  = 2'd3
    } rd_state_t;

    localparam int ROW_BITS  = 512;
    localparam int ROW_BYTES = 64;

    // Int8 rows shrink to one byte per element, i.e. a quarter of the row bits.
    function automatic int beats_per_row(input int axi_width, input logic is_int32);
        return is_int32 ? (ROW_BITS / axi_width) : ((ROW_BITS / 4) / axi_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slave_packer.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_packer
// Description : AXI4 read-channel packer serialising output-buffer rows into R beats.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_packer
    import tc_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int ARRAY_WIDTH     = 16,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_data_type_is_int32,
    input  logic [31:0]                araddr,
    input  logic [7:0]                 arlen,
    input  logic [2:0]                 arsize,
    input  logic [1:0]                 arburst,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [AXI_DATA_WIDTH-1:0]  rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [ADDR_WIDTH-1:0]      host_rd_addr,
    output logic                       host_rd_en,
    input  logic [SRAM_DATA_WIDTH-1:0] host_rd_data [ARRAY_WIDTH]
);

    localparam int BPR_I32 = beats_per_row(AXI_DATA_WIDTH, 1'b1);
    localparam int BPR_I8  = beats_per_row(AXI_DATA_WIDTH, 1'b0);
    localparam int EPB     = AXI_DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int BPB     = AXI_DATA_WIDTH / 8;
    localparam int SLICE_W = 5;
    localparam int IDX_W   = $clog2(ARRAY_WIDTH);

    generate
        if (BPR_I8 < 1) begin : g_bad_width
            $error("axi_slave_packer: AXI_DATA_WIDTH too wide for Int8 row packing");
        end
    endgenerate

    rd_state_t                  r_state;
    rd_state_t                  w_next;
    logic [ADDR_WIDTH-1:0]      r_cur_addr;
    logic [8:0]                 r_beats_left;
    logic                       r_mode;
    logic [SLICE_W-1:0]         r_slice;
    logic [SRAM_DATA_WIDTH-1:0] r_row [ARRAY_WIDTH];
    logic [SLICE_W-1:0]         w_bpr_last;
    logic                       w_row_done;
    logic                       w_unused;

    assign w_unused   = ^{arsize, arburst, araddr[31:ADDR_WIDTH+6], araddr[5:0]};
    assign w_bpr_last = r_mode ? SLICE_W'(BPR_I32 - 1) : SLICE_W'(BPR_I8 - 1);
    assign w_row_done = (r_slice == w_bpr_last);

    assign arready      = (r_state == S_IDLE);
    assign rvalid       = (r_state == S_R_DATA);
    assign host_rd_en   = (r_state == S_RD_REQ);
    assign host_rd_addr = r_cur_addr;
    assign rlast        = rvalid && (r_beats_left == 9'd1);
    assign rresp        = 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (arvalid) w_next = S_RD_REQ;
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_R_DATA;
            S_R_DATA: begin
                if (rready) begin
                    if (r_beats_left == 9'd1) begin
                        w_next = S_IDLE;
                    end else if (w_row_done) begin
                        w_next = S_RD_REQ;
                    end
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_mode       <= 1'b0;
            r_slice      <= '0;
            for (int i = 0; i < ARRAY_WIDTH; i++) begin
                r_row[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arvalid) begin
                        r_cur_addr   <= araddr[ADDR_WIDTH+5:6];
                        r_beats_left <= {1'b0, arlen} + 9'd1;
                        r_mode       <= cfg_data_type_is_int32;
                        r_slice      <= '0;
                    end
                end
                S_RD_WAIT: begin
                    for (int i = 0; i < ARRAY_WIDTH; i++) begin
                        r_row[i] <= host_rd_data[i];
                    end
                end
                S_R_DATA: begin
                    if (rready) begin
                        r_beats_left <= r_beats_left - 9'd1;
                        // Row exhausted mid-burst: fetch the next row, wrapping the address.
                        if (r_beats_left != 9'd1) begin
                            if (w_row_done) begin
                                r_slice    <= '0;
                                r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
                            end else begin
                                r_slice <= r_slice + SLICE_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Int8 keeps only the low byte of each element (plain truncation).
    always_comb begin
        rdata = '0;
        if (r_mode) begin
            for (int j = 0; j < EPB; j++) begin
                rdata[j*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] = r_row[IDX_W'(int'(r_slice) * EPB + j)];
            end
        end else begin
            for (int j = 0; j < BPB; j++) begin
                rdata[j*8 +: 8] = r_row[IDX_W'(int'(r_slice) * BPB + j)][7:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_slave_packer
// Description : Scoreboard bench for axi_slave_packer with a registered SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [9:0]  host_rd_addr;
    logic        host_rd_en;
    logic [31:0] host_rd_data [16];
    logic [31:0] mem [1024][16];

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t      exp_q[$];
    logic [9:0] addr_q[$];
    int         beat_cyc[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         rd_cnt = 0;
    int         cyc = 0;
    logic       stalled = 1'b0;
    logic [63:0] held_d;
    logic        held_l;

    axi_slave_packer #(
        .AXI_DATA_WIDTH (64),
        .SRAM_DATA_WIDTH(32),
        .ARRAY_WIDTH    (16),
        .ADDR_WIDTH     (10)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_data_type_is_int32(cfg),
        .araddr                (araddr),
        .arlen                 (arlen),
        .arsize                (arsize),
        .arburst               (arburst),
        .arvalid               (arvalid),
        .arready               (arready),
        .rdata                 (rdata),
        .rresp                 (rresp),
        .rlast                 (rlast),
        .rvalid                (rvalid),
        .rready                (rready),
        .host_rd_addr          (host_rd_addr),
        .host_rd_en            (host_rd_en),
        .host_rd_data          (host_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (host_rd_en) begin
            for (int i = 0; i < 16; i++) host_rd_data[i] <= mem[host_rd_addr][i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got rdata %h, expected no beat", rdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.d);
                    check("rlast", {63'd0, rlast}, {63'd0, e.l});
                    check("rresp", {62'd0, rresp}, 64'd0);
                    beat_cyc.push_back(cyc);
                end
            end
            if (rvalid && !rready) begin
                if (!stalled) begin
                    stalled = 1'b1;
                    held_d  = rdata;
                    held_l  = rlast;
                end else begin
                    check("stall_rdata", rdata, held_d);
                    check("stall_rlast", {63'd0, rlast}, {63'd0, held_l});
                end
            end else begin
                stalled = 1'b0;
            end
            if (host_rd_en) begin
                rd_cnt++;
                if (addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rd: got addr %0d, expected no read", host_rd_addr);
                end else begin
                    check("rd_addr", {54'd0, host_rd_addr}, {54'd0, addr_q.pop_front()});
                end
            end
        end
    end

    // Expected beats/reads from the tb memory image.
    task automatic push_burst(input int row, input int len, input logic m);
        int r;
        int s;
        int bpr;
        logic [63:0] d;
        r   = row;
        s   = 0;
        bpr = m ? 8 : 2;
        addr_q.push_back(10'(r));
        for (int k = 0; k <= len; k++) begin
            d = '0;
            if (m) begin
                d = {mem[r][2*s+1], mem[r][2*s]};
            end else begin
                for (int j = 0; j < 8; j++) d[j*8 +: 8] = mem[r][8*s+j][7:0];
            end
            exp_q.push_back('{d: d, l: (k == len)});
            if (k != len) begin
                if (s == bpr - 1) begin
                    s = 0;
                    r = (r + 1) % 1024;
                    addr_q.push_back(10'(r));
                end else begin
                    s++;
                end
            end
        end
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] l, input logic m);
        check("arready_before_ar", {63'd0, arready}, 64'd1);
        araddr  = a;
        arlen   = l;
        cfg     = m;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check("reads_outstanding", 64'(addr_q.size()), 64'd0);
        addr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int rd0;
        int n;
        rst = 1'b1; cfg = 1'b0; araddr = '0; arlen = '0; arsize = 3'd3;
        arburst = 2'd1; arvalid = 1'b0; rready = 1'b1;

        @(posedge clk);
        #1;
        check("rst_arready", {63'd0, arready}, 64'd1);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_rlast", {63'd0, rlast}, 64'd0);
        check("rst_rd_en", {63'd0, host_rd_en}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_rd_addr", {54'd0, host_rd_addr}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Int32, row 2, latency and 8 beats
        for (int i = 0; i < 16; i++) mem[2][i] = 32'h1000 + i;
        addr_q.push_back(10'd2);
        for (int k = 0; k < 8; k++) exp_q.push_back('{d: {32'h1000 + 2*k + 1, 32'h1000 + 2*k}, l: (k == 7)});
        issue_ar(32'h80, 8'd7, 1'b1);
        check("t1_rd_en_T1", {63'd0, host_rd_en}, 64'd1);
        check("t1_rvalid_T1", {63'd0, rvalid}, 64'd0);
        @(posedge clk);
        #1;
        check("t1_rvalid_T2", {63'd0, rvalid}, 64'd0);
        @(posedge clk);
        #1;
        check("t1_rvalid_T3", {63'd0, rvalid}, 64'd1);
        wait_drain();

        // Int8 across rows 1 -> 2
        for (int i = 0; i < 16; i++) begin
            mem[1][i] = 32'hFFFF_FF80 + i;
            mem[2][i] = i;
        end
        addr_q.push_back(10'd1);
        addr_q.push_back(10'd2);
        exp_q.push_back('{d: 64'h8786_8584_8382_8180, l: 1'b0});
        exp_q.push_back('{d: 64'h8F8E_8D8C_8B8A_8988, l: 1'b0});
        exp_q.push_back('{d: 64'h0706_0504_0302_0100, l: 1'b0});
        exp_q.push_back('{d: 64'h0F0E_0D0C_0B0A_0908, l: 1'b1});
        beat_cyc.delete();
        issue_ar(32'h40, 8'd3, 1'b0);
        wait_drain();
        check("t2_beat_count", 64'(beat_cyc.size()), 64'd4);
        if (beat_cyc.size() == 4) begin
            check("t2_gap_in_row", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
            check("t2_gap_between_rows", 64'(beat_cyc[2] - beat_cyc[1]), 64'd3);
        end

        // Backpressure on beat 3
        for (int i = 0; i < 16; i++) mem[5][i] = 32'h5000 + i;
        push_burst(5, 7, 1'b1);
        rd0 = rd_cnt;
        issue_ar(32'h140, 8'd7, 1'b1);
        n = 0;
        while (exp_q.size() != 5 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        rready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rready = 1'b1;
        wait_drain();
        check("t3_rd_count", 64'(rd_cnt - rd0), 64'd1);

        // Address wrap 1023 -> 0, Int8
        for (int i = 0; i < 16; i++) begin
            mem[1023][i] = 32'h1234_56A0 + i;
            mem[0][i]    = 32'h0000_0050 + i;
        end
        push_burst(1023, 3, 1'b0);
        issue_ar(32'h0000_FFC0, 8'd3, 1'b0);
        wait_drain();

        // Single beat, cfg toggled after handshake
        for (int i = 0; i < 16; i++) mem[7][i] = 32'h7000_0000 + i;
        push_burst(7, 0, 1'b1);
        issue_ar(32'h1C0, 8'd0, 1'b1);
        cfg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_rvalid", {63'd0, rvalid}, 64'd1);
        check("t5_rlast", {63'd0, rlast}, 64'd1);
        @(posedge clk);
        #1;
        check("t5_arready_after", {63'd0, arready}, 64'd1);
        check("t5_rvalid_after", {63'd0, rvalid}, 64'd0);
        wait_drain();

        // Async reset during beat 2, then a clean burst
        for (int i = 0; i < 16; i++) mem[3][i] = 32'h3000 + 3*i;
        push_burst(3, 7, 1'b1);
        issue_ar(32'hC0, 8'd7, 1'b1);
        n = 0;
        while (exp_q.size() != 6 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("t6_rst_arready", {63'd0, arready}, 64'd1);
        check("t6_rst_rd_en", {63'd0, host_rd_en}, 64'd0);
        check("t6_rst_rdata", rdata, 64'd0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_burst(3, 3, 1'b1);
        issue_ar(32'hC0, 8'd3, 1'b1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
